trdb_packet_arbiter: RTL
========================

# trdb_packet_arbiter

Round-robin arbiter that shares the trace debugger's single packet output stream (`packet_word`/`packet_word_valid`/`grant`) between several packet sources, e.g. the instruction-trace encoder and software-injected user packets. Multi-word packets are never interleaved: once a source wins, it owns the output until its `last` word is accepted. A one-word output register decouples the sources from downstream backpressure and sustains one word per cycle.

## Interface
- `NREQ`, default 2, number of requesters (≥1).
- `XLEN`, default `trdb_pkg::XLEN` (32), packet word width.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `enable_i` in 1: permit new packets to start; an in-flight packet always completes.
- `req_word_i` in NREQ×XLEN: per-requester packet word.
- `req_valid_i` in NREQ: requester has a word.
- `req_last_i` in NREQ: word is the final word of its packet.
- `req_ready_o` out NREQ: word accepted this cycle when `req_valid_i & req_ready_o`.
- `packet_word_o` out XLEN: output word.
- `packet_word_valid_o` out 1: output word valid.
- `grant_i` in 1: downstream accepts the output word when high with valid.
- `owner_o` out max(1,$clog2(NREQ)): index of the current or last owner.
- `busy_o` out 1: state is LOCKED or output register full.

## Operation
- Output register: `slot_free = !packet_word_valid_o || grant_i`. A requester word is accepted only when `slot_free`.
- States (`trdb_pkg::arb_state_e`): IDLE, LOCKED.
- IDLE: if `enable_i` and any `req_valid_i`, pick the first valid index at or cyclically after `rr_ptr`. That index gets `req_ready_o = slot_free`; all others get 0. On acceptance:
  - set `owner_o` = winner;
  - if `req_last_i`, stay IDLE and set `rr_ptr` = winner+1 mod NREQ;
  - otherwise go to LOCKED.
- LOCKED: only `owner_o` may receive `req_ready_o = slot_free`; `enable_i` is ignored. When a `last` word is accepted, go to IDLE and set `rr_ptr` = owner+1 mod NREQ.
- If `enable_i` is low in IDLE, all `req_ready_o` are 0. The output register still drains.
- NREQ=1: degenerates to a registered pass-through with enable gating at packet starts.
- `rr_ptr` wraps from NREQ−1 to 0. NREQ that is not a power of 2 requires an explicit compare, not a bit overflow.

## Timing
- Reset values: `packet_word_o`=0, `packet_word_valid_o`=0, `owner_o`=0, `busy_o`=0, state IDLE, `rr_ptr`=0. `req_ready_o`=0 while in reset.
- Latency: a word accepted in cycle N appears at `packet_word_o` with valid in N+1.
- Throughput: while `grant_i` is held high, one word per cycle with no bubbles, including across packet boundaries and between different owners.
- Stall: with valid high and `grant_i` low, `packet_word_o` holds stable and all `req_ready_o` are 0.
- `req_ready_o` is combinational from state, `rr_ptr`, `req_valid_i`, `enable_i`, `packet_word_valid_o` and `grant_i`. It must not depend on `req_word_i` or `req_last_i`.
- Reset asserted mid-packet: immediate return to reset values; a partial packet is discarded and not resumed.
- Arbitration decision and acceptance occur in the same cycle; there is no dedicated arbitration cycle.

## Structure
- `trdb_pkg` additions: `arb_state_e` typedef {ARB_IDLE, ARB_LOCKED}. XLEN is reused from the package.
- Sub-module `trdb_rr_pick`: combinational, parameter NREQ. Inputs are the request vector and `rr_ptr`; outputs are a one-hot grant and a valid flag.
- Top holds the FSM, `rr_ptr`, owner and output register; target 150–250 lines.

## Test plan
- **Single-word packets.** NREQ=2, both requesters hold 1-word packets, `grant_i`=1. Required: output alternates 0,1,0,1 at one word per cycle; `owner_o` toggles each cycle.
- **No interleaving.** Req0 sends a 3-word packet A0..A2 while req1 is valid throughout. Required: output is A0,A1,A2 then req1's word; `req_ready_o[1]`=0 until A2 is accepted.
- **Backpressure.** `grant_i`=0 for 4 cycles mid-packet. Required: `packet_word_o` is stable, `req_ready_o`=0, and no word is lost or duplicated after `grant_i` returns.
- **Enable.** Drop `enable_i` during word 1 of a 3-word packet. Required: the packet completes, no new packet starts, and `busy_o` falls once the last word is granted.
- **Reset mid-packet.** Assert `rst_i` asynchronously between clock edges during a LOCKED packet. Required: outputs drop to reset values immediately, and after release the arbitration restarts at requester 0.
- **Wrap-around.** NREQ=3 with all requesters valid. Required: grant order 0,1,2,0,1,2; `rr_ptr` never reaches 3.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace debugger packet path.
// Holds the word width and the arbiter state encoding.
package trdb_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/trdb_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i.
// Wraps by explicit compare so any NREQ works.
module trdb_rr_pick #(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = ptr_i;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
      idx = (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
    end
  end

endmodule

// File: rtl/trdb_packet_arbiter.sv
// Round-robin packet arbiter with packet locking and a one-word
// output register that sustains one word per cycle under grant.
module trdb_packet_arbiter #(
  parameter  int NREQ = 2,
  parameter  int XLEN = trdb_pkg::XLEN,
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [NREQ-1:0][XLEN-1:0] req_word_i,
  input  logic [NREQ-1:0]           req_valid_i,
  input  logic [NREQ-1:0]           req_last_i,
  output logic [NREQ-1:0]           req_ready_o,
  output logic [XLEN-1:0]           packet_word_o,
  output logic                      packet_word_valid_o,
  input  logic                      grant_i,
  output logic [OW-1:0]             owner_o,
  output logic                      busy_o
);

  import trdb_pkg::*;

  arb_state_e      state_q, state_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [XLEN-1:0] word_q, word_d;
  logic            valid_q, valid_d;

  logic            slot_free;
  logic            pick_valid;
  logic [NREQ-1:0] pick_gnt;
  logic [NREQ-1:0] ready;
  logic [OW-1:0]   sel;
  logic [OW-1:0]   sel_next;
  logic            acc;

  trdb_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_i  (req_valid_i),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (pick_gnt),
    .valid_o(pick_valid)
  );

  assign slot_free = !valid_q || grant_i;

  always_comb begin
    sel = owner_q;
    if (state_q == ARB_IDLE) begin
      sel = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (pick_gnt[i]) sel = OW'(i);
      end
    end
  end

  assign sel_next = (sel == OW'(NREQ - 1)) ? '0 : sel + OW'(1);

  // Ready never looks at word or last, only at arbitration state.
  always_comb begin
    ready = '0;
    if (!rst_i && slot_free) begin
      unique case (1'b1)
        (state_q == ARB_LOCKED):
          ready[sel] = 1'b1;
        (state_q == ARB_IDLE) && enable_i && pick_valid:
          ready = pick_gnt;
        default:
          ready = '0;
      endcase
    end
  end

  assign acc = req_valid_i[sel] & ready[sel];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    word_d   = word_q;
    valid_d  = valid_q;
    if (grant_i) valid_d = 1'b0;
    if (acc) begin
      word_d  = req_word_i[sel];
      valid_d = 1'b1;
      owner_d = sel;
      if (req_last_i[sel]) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = sel_next;
      end else begin
        state_d  = ARB_LOCKED;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
    end
  end

  assign req_ready_o         = ready;
  assign packet_word_o       = word_q;
  assign packet_word_valid_o = valid_q;
  assign owner_o             = owner_q;
  assign busy_o              = (state_q == ARB_LOCKED) || valid_q;

endmodule
